// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: shared state encoding and retry limit for the PLL reset sequencer
package pll_rst_pkg;
  typedef enum logic [2:0] {LOCK_WAIT, SDR_INIT, PERIPH_REL, RUN, SOFT_RST, FAULT} state_t;
  localparam int MAX_INIT_RETRIES = 3;
endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level, clears to 0
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk)
    if (rst) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: qualifies PLL lock and releases SDRAM, peripheral, then CPU resets in order
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int SDR_INIT_TIMEOUT   = 65535,
  parameter int PERIPH_DELAY       = 16,
  parameter int SOFT_RST_CYCLES    = 64
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic sdr_init_done,
  input  logic soft_rst_req,
  output logic sdr_rst,
  output logic periph_rst,
  output logic cpu_rst,
  output logic sys_ready,
  output logic init_fault
);
  localparam int LW   = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW   = $clog2(SDR_INIT_TIMEOUT + 1);
  localparam int DMAX = PERIPH_DELAY > SOFT_RST_CYCLES ? PERIPH_DELAY : SOFT_RST_CYCLES;
  localparam int DW   = $clog2(DMAX + 1);
  localparam int RW   = $clog2(MAX_INIT_RETRIES + 1);
  if (LOCK_STABLE_CYCLES < 1 || SDR_INIT_TIMEOUT < 1 || PERIPH_DELAY < 1 || SOFT_RST_CYCLES < 1) begin : g_bad_param
    $error("pll_reset_sequencer: all cycle parameters must be >= 1");
  end
  state_t state, state_n;
  logic lk_s;
  logic [LW-1:0] lock_cnt, lock_cnt_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;
  logic [DW-1:0] dly_cnt, dly_cnt_n;
  logic [RW-1:0] retry_cnt, retry_cnt_n;
  logic sdr_rst_n, periph_rst_n, cpu_rst_n, sys_ready_n, init_fault_n;
  sync_2ff u_lock_sync (
    .clk(sys_clk),
    .rst(rst),
    .d  (pll_locked),
    .q  (lk_s)
  );
  always_ff @(posedge sys_clk)
    if (rst) begin
      state      <= LOCK_WAIT;
      lock_cnt   <= '0;
      tmo_cnt    <= '0;
      dly_cnt    <= '0;
      retry_cnt  <= '0;
      sdr_rst    <= 1'b1;
      periph_rst <= 1'b1;
      cpu_rst    <= 1'b1;
      sys_ready  <= 1'b0;
      init_fault <= 1'b0;
    end else begin
      state      <= state_n;
      lock_cnt   <= lock_cnt_n;
      tmo_cnt    <= tmo_cnt_n;
      dly_cnt    <= dly_cnt_n;
      retry_cnt  <= retry_cnt_n;
      sdr_rst    <= sdr_rst_n;
      periph_rst <= periph_rst_n;
      cpu_rst    <= cpu_rst_n;
      sys_ready  <= sys_ready_n;
      init_fault <= init_fault_n;
    end
  // Counters default to zero so every state entry starts from a clean count.
  always_comb begin
    state_n     = state;
    lock_cnt_n  = '0;
    tmo_cnt_n   = '0;
    dly_cnt_n   = '0;
    retry_cnt_n = retry_cnt;
    case (state)
      LOCK_WAIT:
        if (lk_s) begin
          if (lock_cnt == LW'(LOCK_STABLE_CYCLES - 1)) state_n = SDR_INIT;
          else lock_cnt_n = lock_cnt + 1'b1;
        end
      SDR_INIT:
        if (!lk_s) state_n = LOCK_WAIT;
        else if (tmo_cnt == TW'(SDR_INIT_TIMEOUT - 1)) begin
          retry_cnt_n = retry_cnt + 1'b1;
          state_n     = (retry_cnt_n == RW'(MAX_INIT_RETRIES)) ? FAULT : LOCK_WAIT;
        end else if (sdr_init_done && int'(tmo_cnt) >= 2) begin
          state_n     = PERIPH_REL;
          retry_cnt_n = '0;
        end else tmo_cnt_n = tmo_cnt + 1'b1;
      PERIPH_REL:
        if (!lk_s) state_n = LOCK_WAIT;
        else if (dly_cnt == DW'(PERIPH_DELAY - 1)) state_n = RUN;
        else dly_cnt_n = dly_cnt + 1'b1;
      RUN:
        state_n = !lk_s ? LOCK_WAIT : soft_rst_req ? SOFT_RST : RUN;
      SOFT_RST:
        if (!lk_s) state_n = LOCK_WAIT;
        else if (dly_cnt == DW'(SOFT_RST_CYCLES - 1)) state_n = PERIPH_REL;
        else dly_cnt_n = dly_cnt + 1'b1;
      default: state_n = FAULT;
    endcase
    sdr_rst_n    = state_n inside {LOCK_WAIT, FAULT};
    periph_rst_n = !(state_n inside {PERIPH_REL, RUN});
    cpu_rst_n    = state_n != RUN;
    sys_ready_n  = state_n == RUN;
    init_fault_n = init_fault | (state_n == FAULT);
  end
endmodule
